// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: the per-cycle violation capture record and error-record FSM states.
package rv_iopmp_pkg;

   // Widest source id carried by the capture record; users may consume fewer bits.
   localparam int unsigned ERR_SID_WIDTH = 8;

   localparam logic [1:0] TTYPE_READ  = 2'd1;
   localparam logic [1:0] TTYPE_WRITE = 2'd2;
   localparam logic [1:0] TTYPE_EXEC  = 2'd3;

   typedef struct packed {
      logic                     error_detected;
      logic [1:0]               ttype;
      logic [2:0]               etype;
      logic [63:0]              addr;
      logic [ERR_SID_WIDTH-1:0] sid;
      logic [15:0]              eid;
   } error_capture_t;

   typedef enum logic [0:0] {
      ERR_IDLE = 1'b0,
      ERR_HELD = 1'b1
   } err_rec_state_t;

endpackage

// File: rtl/rv_iopmp_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
module rv_iopmp_sat_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [WIDTH-1:0] count_o,
   output logic             saturated_o,
   output logic             overflow_o
);

   logic [WIDTH-1:0] count_q;
   logic             overflow_q;
   logic             at_max;

   assign at_max = &count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (clr_i) begin
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else if (inc_i) begin
         // An increment arriving at all-ones is the one that gets lost.
         if (at_max) begin
            overflow_q <= 1'b1;
         end else begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign count_o     = count_q;
   assign saturated_o = at_max;
   assign overflow_o  = overflow_q;

endmodule

// File: rtl/rv_iopmp_error_record.sv
// IOPMP error record: holds the first violation, counts later ones, drives the wired interrupt.
module rv_iopmp_error_record
   import rv_iopmp_pkg::*;
#(
   parameter int unsigned SID_WIDTH = 8,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  error_capture_t       err_interface_i,
   input  logic                 ie_i,
   input  logic                 ire_i,
   input  logic                 iwe_i,
   input  logic                 clear_i,
   output logic                 ip_o,
   output logic [1:0]           ttype_o,
   output logic [2:0]           etype_o,
   output logic [31:0]          err_reqaddr_o,
   output logic [31:0]          err_reqaddrh_o,
   output logic [SID_WIDTH-1:0] err_sid_o,
   output logic [15:0]          err_eid_o,
   output logic [CNT_WIDTH-1:0] suppressed_cnt_o,
   output logic                 overflow_o,
   output logic                 wired_int_o
);

   err_rec_state_t state_q, state_d;

   logic [1:0]           ttype_q;
   logic [2:0]           etype_q;
   logic [63:0]          addr_q;
   logic [SID_WIDTH-1:0] sid_q;
   logic [15:0]          eid_q;

   logic event_valid;
   logic capture;
   logic cnt_inc;
   logic cnt_clr;
   logic cnt_saturated;

   assign event_valid = err_interface_i.error_detected;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         ERR_IDLE: begin
            if (event_valid) begin
               state_d = ERR_HELD;
               capture = 1'b1;
            end
         end
         ERR_HELD: begin
            if (clear_i && event_valid) begin
               // Clear racing a new violation: keep the new one rather than lose it.
               capture = 1'b1;
            end else if (clear_i) begin
               state_d = ERR_IDLE;
            end else if (event_valid) begin
               cnt_inc = 1'b1;
            end
         end
         default: state_d = ERR_IDLE;
      endcase
   end

   // A clear in IDLE hits an already-zero counter, so it needs no state gating.
   assign cnt_clr = clear_i | capture;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ERR_IDLE;
         ttype_q <= '0;
         etype_q <= '0;
         addr_q  <= '0;
         sid_q   <= '0;
         eid_q   <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            ttype_q <= err_interface_i.ttype;
            etype_q <= err_interface_i.etype;
            addr_q  <= err_interface_i.addr;
            sid_q   <= err_interface_i.sid[SID_WIDTH-1:0];
            eid_q   <= err_interface_i.eid;
         end
      end
   end

   rv_iopmp_sat_counter #(
      .WIDTH(CNT_WIDTH)
   ) u_sat_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (cnt_inc),
      .clr_i      (cnt_clr),
      .count_o    (suppressed_cnt_o),
      .saturated_o(cnt_saturated),
      .overflow_o (overflow_o)
   );

   always_comb begin
      wired_int_o = 1'b0;
      if (state_q == ERR_HELD && ie_i) begin
         wired_int_o = (((ttype_q == TTYPE_READ) || (ttype_q == TTYPE_EXEC)) && ire_i) ||
                       ((ttype_q == TTYPE_WRITE) && iwe_i);
      end
   end

   assign ip_o           = (state_q == ERR_HELD);
   assign ttype_o        = ttype_q;
   assign etype_o        = etype_q;
   assign err_reqaddr_o  = addr_q[31:0];
   assign err_reqaddrh_o = addr_q[63:32];
   assign err_sid_o      = sid_q;
   assign err_eid_o      = eid_q;

   logic unused_saturated;
   assign unused_saturated = cnt_saturated;

endmodule

// File: tb/tb_rv_iopmp_error_record.sv
// Directed bench for the IOPMP error record, small counter to reach saturation quickly.
module tb_rv_iopmp_error_record;
   import rv_iopmp_pkg::*;

   localparam int unsigned SID_WIDTH = 8;
   localparam int unsigned CNT_WIDTH = 2;

   logic                 clk = 1'b0;
   logic                 rst_ni;
   error_capture_t       err_interface_i;
   logic                 ie_i, ire_i, iwe_i, clear_i;
   logic                 ip_o;
   logic [1:0]           ttype_o;
   logic [2:0]           etype_o;
   logic [31:0]          err_reqaddr_o, err_reqaddrh_o;
   logic [SID_WIDTH-1:0] err_sid_o;
   logic [15:0]          err_eid_o;
   logic [CNT_WIDTH-1:0] suppressed_cnt_o;
   logic                 overflow_o, wired_int_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_iopmp_error_record #(
      .SID_WIDTH(SID_WIDTH),
      .CNT_WIDTH(CNT_WIDTH)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .err_interface_i (err_interface_i),
      .ie_i            (ie_i),
      .ire_i           (ire_i),
      .iwe_i           (iwe_i),
      .clear_i         (clear_i),
      .ip_o            (ip_o),
      .ttype_o         (ttype_o),
      .etype_o         (etype_o),
      .err_reqaddr_o   (err_reqaddr_o),
      .err_reqaddrh_o  (err_reqaddrh_o),
      .err_sid_o       (err_sid_o),
      .err_eid_o       (err_eid_o),
      .suppressed_cnt_o(suppressed_cnt_o),
      .overflow_o      (overflow_o),
      .wired_int_o     (wired_int_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ev(input logic [1:0] tt, input logic [2:0] et, input logic [7:0] sid,
                         input logic [15:0] eid, input logic [63:0] addr);
      err_interface_i.error_detected = 1'b1;
      err_interface_i.ttype          = tt;
      err_interface_i.etype          = et;
      err_interface_i.sid            = sid;
      err_interface_i.eid            = eid;
      err_interface_i.addr           = addr;
   endtask

   task automatic no_ev();
      err_interface_i.error_detected = 1'b0;
   endtask

   initial begin
      logic [1:0] exp_cnt [5];
      logic       exp_ovf [5];
      exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      err_interface_i = '0;
      ie_i    = 1'b1;
      ire_i   = 1'b0;
      iwe_i   = 1'b1;
      clear_i = 1'b0;
      rst_ni  = 1'b0;

      // Reset with an event present: event must be dropped.
      set_ev(2'd2, 3'd1, 8'd5, 16'd3, 64'h0000_0001_8000_0040);
      step();
      step();
      check("rst_ip", ip_o, 0);
      check("rst_addr", err_reqaddr_o, 0);
      check("rst_addrh", err_reqaddrh_o, 0);
      check("rst_sid", err_sid_o, 0);
      check("rst_cnt", suppressed_cnt_o, 0);
      check("rst_ovf", overflow_o, 0);
      check("rst_int", wired_int_o, 0);
      no_ev();
      rst_ni = 1'b1;
      step();
      check("post_rst_ip", ip_o, 0);

      // Single capture of a write violation.
      set_ev(2'd2, 3'd1, 8'd5, 16'd3, 64'h0000_0001_8000_0040);
      step();
      no_ev();
      check("cap_ip", ip_o, 1);
      check("cap_addrh", err_reqaddrh_o, 32'h1);
      check("cap_addr", err_reqaddr_o, 32'h8000_0040);
      check("cap_ttype", ttype_o, 2);
      check("cap_etype", etype_o, 1);
      check("cap_sid", err_sid_o, 5);
      check("cap_eid", err_eid_o, 3);
      check("cap_cnt", suppressed_cnt_o, 0);
      check("cap_int", wired_int_o, 1);
      iwe_i = 1'b0;
      #1;
      check("cap_int_iwe0", wired_int_o, 0);
      iwe_i = 1'b1;

      // Suppression until saturation; record must stay on the first event.
      for (int i = 0; i < 5; i++) begin
         set_ev(2'd1, 3'd4, 8'd20 + 8'(i), 16'd7, 64'h10 * (i + 1));
         step();
         check("sup_cnt", suppressed_cnt_o, exp_cnt[i]);
         check("sup_ovf", overflow_o, exp_ovf[i]);
         check("sup_addr", err_reqaddr_o, 32'h8000_0040);
      end
      no_ev();
      step();
      check("sup_sid", err_sid_o, 5);
      check("sup_cnt_hold", suppressed_cnt_o, 3);

      // Clear with no event: record fields retained.
      clear_i = 1'b1;
      step();
      clear_i = 1'b0;
      check("clr_ip", ip_o, 0);
      check("clr_cnt", suppressed_cnt_o, 0);
      check("clr_ovf", overflow_o, 0);
      check("clr_int", wired_int_o, 0);
      check("clr_addr_kept", err_reqaddr_o, 32'h8000_0040);
      check("clr_sid_kept", err_sid_o, 5);

      // New read violation captured after clear; ire_i=0 so no interrupt.
      set_ev(2'd1, 3'd2, 8'd7, 16'h10, 64'h0000_0002_0000_1000);
      step();
      check("recap_ip", ip_o, 1);
      check("recap_sid", err_sid_o, 7);
      check("recap_addrh", err_reqaddrh_o, 2);
      check("recap_addr", err_reqaddr_o, 32'h1000);
      check("recap_int", wired_int_o, 0);
      set_ev(2'd1, 3'd2, 8'd8, 16'h11, 64'h2000);
      step();
      check("recap_cnt", suppressed_cnt_o, 1);

      // Clear and event together: new event wins, counter restarts.
      clear_i = 1'b1;
      set_ev(2'd2, 3'd3, 8'd9, 16'h22, 64'h0000_0003_0000_3000);
      step();
      clear_i = 1'b0;
      no_ev();
      check("race_ip", ip_o, 1);
      check("race_sid", err_sid_o, 9);
      check("race_addrh", err_reqaddrh_o, 3);
      check("race_cnt", suppressed_cnt_o, 0);

      // Clear in IDLE is ignored.
      clear_i = 1'b1;
      step();
      step();
      clear_i = 1'b0;
      check("idle_clr_ip", ip_o, 0);

      // Exec violation interrupts via ire_i; ie_i gates it combinationally.
      ire_i = 1'b1;
      iwe_i = 1'b0;
      set_ev(2'd3, 3'd5, 8'd4, 16'h5, 64'h4000);
      step();
      no_ev();
      check("exec_ttype", ttype_o, 3);
      check("exec_int", wired_int_o, 1);
      ie_i = 1'b0;
      #1;
      check("exec_int_ie0", wired_int_o, 0);
      ie_i = 1'b1;

      // Reset mid-HELD discards the record.
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      check("rst_held_ip", ip_o, 0);
      check("rst_held_addr", err_reqaddr_o, 0);
      check("rst_held_ttype", ttype_o, 0);
      check("rst_held_int", wired_int_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_iopmp_error_record.md
# rv_iopmp_error_record

Error-record unit that consumes the per-cycle `error_capture_t` stream produced by the IOPMP transaction-checking logic. It holds the first violation as the architectural ERR_REQINFO/ERR_REQADDR/ERR_REQADDRH/ERR_REQID record and counts later violations until software clears the record. It also drives the IOPMP wired interrupt. It sits between the matching logic and the register file: the register file reads its outputs and forwards W1C/enable writes.

## Interface
- `SID_WIDTH`, 8: width of `err_reqid.sid` as carried by `error_capture_t`.
- `CNT_WIDTH`, 8: width of the suppressed-error counter (saturating).
- `clk_i` in 1: rising-edge clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `err_interface_i` in `error_capture_t`: violation event. Valid in any cycle with `error_detected`=1; one event per such cycle.
- `ie_i` in 1: global interrupt enable (ERR_CFG.ie).
- `ire_i` in 1: interrupt on read/execute violations.
- `iwe_i` in 1: interrupt on write violations.
- `clear_i` in 1: single-cycle pulse, software W1C of ERR_REQINFO.ip.
- `ip_o` out 1: record valid / interrupt pending.
- `ttype_o` out 2: captured transaction type (1 read, 2 write, 3 exec).
- `etype_o` out 3: captured error type.
- `err_reqaddr_o` out 32: captured address, low word.
- `err_reqaddrh_o` out 32: captured address, high word.
- `err_sid_o` out `SID_WIDTH`: captured source id.
- `err_eid_o` out 16: captured entry index.
- `suppressed_cnt_o` out `CNT_WIDTH`: violations dropped while `ip_o`=1.
- `overflow_o` out 1: counter saturated (sticky until clear).
- `wired_int_o` out 1: interrupt line.

## Operation
- FSM states: IDLE (no record) and HELD (record valid). `ip_o` = (state==HELD).
- IDLE, event: latch all fields from `err_interface_i`, go to HELD, counter=0.
- IDLE, no event: hold. Record registers keep their last values; they are not cleared on W1C.
- HELD, event, no clear: record unchanged. Counter +1 unless it equals all-ones, in which case it stays at all-ones and sets `overflow_o`.
- HELD, clear, no event: go to IDLE. Counter=0, overflow=0.
- HELD, clear and event in the same cycle: the new event is captured (record overwritten), state stays HELD, counter=0, overflow=0. No violation is lost.
- IDLE, clear: ignored.
- `ttype` 0 (reserved) in an event is captured as-is. This block does not filter it.
- Interrupt: `wired_int_o` = HELD & `ie_i` & ((ttype∈{1,3} & `ire_i`) | (ttype==2 & `iwe_i`)). It is level and combinational from registered state and live enables, so it tracks enable changes in the same cycle.

## Timing
- Capture latency 1 cycle: an event at edge N shows on `ip_o`/record outputs after edge N.
- Clear latency 1 cycle: `ip_o` and `wired_int_o` fall after the clock edge that samples `clear_i`.
- Counter updates 1 cycle after each suppressed event. Back-to-back events count once per cycle.
- Reset (`rst_ni`=0 at an edge) puts the FSM in IDLE and zeroes every record register, the counter and overflow. All outputs read 0 after that edge.
- Reset asserted mid-HELD discards the record. An event coincident with reset is dropped.
- All outputs are registered except `wired_int_o`.

## Structure
- `rv_iopmp_pkg` holds the FSM state enum `err_rec_state_t` {ERR_IDLE, ERR_HELD}, plus `TTYPE_READ`=1, `TTYPE_WRITE`=2, `TTYPE_EXEC`=3. `error_capture_t` already lives there.
- Sub-module `rv_iopmp_sat_counter`: parameterised width, with inc, clr and saturated flag.
- Single always_ff for the FSM and record; the interrupt is a separate always_comb.

## Test plan
- Reset: hold `rst_ni`=0 two cycles with an event present -> all outputs 0, `ip_o`=0 afterwards.
- Single capture: event {ttype=2, etype=1, sid=5, eid=3, addr=0x0000_0001_8000_0040}, `ie_i`=`iwe_i`=1 -> next cycle `ip_o`=1, `err_reqaddrh_o`=0x1, `err_reqaddr_o`=0x80000040, `wired_int_o`=1. With `iwe_i`=0 -> `wired_int_o`=0.
- Suppression and saturation (`CNT_WIDTH`=2): capture, then 5 consecutive events with different addresses -> record equals the first event, count 1,2,3,3,3, `overflow_o`=1 from the 4th.
- Clear: pulse `clear_i` with no event -> `ip_o`=0, count=0, overflow=0 next cycle, record fields retained. A further event is captured.
- Clear and event in the same cycle (event sid=9) -> `ip_o` stays 1, `err_sid_o`=9, count=0.
- Exec interrupt: capture ttype=3 with `ire_i`=1, `iwe_i`=0, `ie_i`=1 -> `wired_int_o`=1. Drop `ie_i` -> `wired_int_o`=0 in the same cycle.
